// File: rtl/music_sequencer.sv
// Background tune player: steps a note ROM at a fixed tempo and
// turns each captured note index into a square wave on the audio pin.
module music_sequencer #(
   parameter int unsigned BEAT_CYCLES = 12_500_000,
   parameter int unsigned GAP_CYCLES  = 1_000_000,
   parameter int unsigned SONG_LEN    = 32,
   parameter int unsigned DIV_SHIFT   = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       restart,
   input  logic [7:0] note_in,
   output logic [7:0] rom_addr,
   output logic       audio_out,
   output logic       audio_en,
   output logic [7:0] cur_note,
   output logic       song_wrap
);

   localparam logic [23:0] PLAY_LAST = 24'(BEAT_CYCLES - GAP_CYCLES - 1);
   localparam logic [23:0] BEAT_LAST = 24'(BEAT_CYCLES - 1);
   localparam logic [7:0]  ADDR_LAST = 8'(SONG_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_PLAY,
      S_GAP
   } state_t;

   state_t      state_q;
   logic [7:0]  addr_q;
   logic [23:0] beat_q;
   logic [19:0] tone_q;
   logic [19:0] half_q;
   logic [7:0]  note_q;
   logic        out_q;
   logic        en_q;
   logic        wrap_q;

   logic [3:0]  semi_d;
   logic [7:0]  oct_d;
   logic [31:0] shift_d;
   logic [19:0] half_d;
   logic        rest_d;

   // Lowest-octave half-periods (clocks at 100 MHz) for C..B.
   function automatic logic [19:0] base_half(input logic [3:0] s);
      logic [19:0] h;
      case (s)
         4'd0:    h = 20'd764451;
         4'd1:    h = 20'd721547;
         4'd2:    h = 20'd681050;
         4'd3:    h = 20'd642826;
         4'd4:    h = 20'd606745;
         4'd5:    h = 20'd572691;
         4'd6:    h = 20'd540549;
         4'd7:    h = 20'd510209;
         4'd8:    h = 20'd481575;
         4'd9:    h = 20'd454545;
         4'd10:   h = 20'd429034;
         4'd11:   h = 20'd404953;
         default: h = 20'd0;
      endcase
      return h;
   endfunction

   // Pitch decode: each octave halves the period; big shifts give a rest.
   always_comb begin
      semi_d  = 4'(note_q % 8'd12);
      oct_d   = note_q / 8'd12;
      shift_d = 32'(oct_d) + 32'(DIV_SHIFT);
      half_d  = 20'd0;
      if (shift_d < 32'd20) begin
         half_d = base_half(semi_d) >> shift_d;
      end
      rest_d = (note_q == 8'd0) || (half_d == 20'd0);
   end

   // Slot sequencer FSM with tone generator and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= 8'd0;
         beat_q  <= 24'd0;
         tone_q  <= 20'd0;
         half_q  <= 20'd0;
         note_q  <= 8'd0;
         out_q   <= 1'b0;
         en_q    <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (!enable) begin
         state_q <= S_IDLE;
         beat_q  <= 24'd0;
         tone_q  <= 20'd0;
         out_q   <= 1'b0;
         en_q    <= 1'b0;
         wrap_q  <= 1'b0;
         if (restart) begin
            addr_q <= 8'd0;
         end
      end else if (restart) begin
         state_q <= S_FETCH;
         addr_q  <= 8'd0;
         beat_q  <= 24'd0;
         tone_q  <= 20'd0;
         out_q   <= 1'b0;
         en_q    <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH;
               beat_q  <= 24'd0;
            end
            S_FETCH: begin
               beat_q <= beat_q + 24'd1;
               if (beat_q == 24'd1) begin
                  note_q  <= note_in;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               beat_q  <= beat_q + 24'd1;
               half_q  <= half_d;
               tone_q  <= 20'd0;
               out_q   <= 1'b0;
               en_q    <= !rest_d;
               state_q <= S_PLAY;
            end
            S_PLAY: begin
               beat_q <= beat_q + 24'd1;
               if (beat_q == PLAY_LAST) begin
                  state_q <= S_GAP;
                  tone_q  <= 20'd0;
                  out_q   <= 1'b0;
                  en_q    <= 1'b0;
               end else if (en_q) begin
                  if (tone_q == half_q - 20'd1) begin
                     tone_q <= 20'd0;
                     out_q  <= ~out_q;
                  end else begin
                     tone_q <= tone_q + 20'd1;
                  end
               end
            end
            S_GAP: begin
               if (beat_q == BEAT_LAST) begin
                  beat_q  <= 24'd0;
                  state_q <= S_FETCH;
                  if (addr_q == ADDR_LAST) begin
                     addr_q <= 8'd0;
                     wrap_q <= 1'b1;
                  end else begin
                     addr_q <= addr_q + 8'd1;
                  end
               end else begin
                  beat_q <= beat_q + 24'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rom_addr  = addr_q;
   assign audio_out = out_q;
   assign audio_en  = en_q;
   assign cur_note  = note_q;
   assign song_wrap = wrap_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a 1-cycle-latency ROM model.
// Timing is tracked by counting clock edges from each slot start.
module tb_music_sequencer;

   localparam int BEAT = 2000;
   localparam int GAP  = 200;
   localparam int SL   = 32;
   localparam int DS   = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       restart = 1'b0;
   logic [7:0] note_in;
   logic [7:0] rom_addr;
   logic       audio_out;
   logic       audio_en;
   logic [7:0] cur_note;
   logic       song_wrap;

   logic [7:0] rom [0:255];

   int compared = 0;
   int mismatched = 0;
   int nclk = 0;
   int base = 0;

   music_sequencer #(
      .BEAT_CYCLES(BEAT),
      .GAP_CYCLES (GAP),
      .SONG_LEN   (SL),
      .DIV_SHIFT  (DS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .restart  (restart),
      .note_in  (note_in),
      .rom_addr (rom_addr),
      .audio_out(audio_out),
      .audio_en (audio_en),
      .cur_note (cur_note),
      .song_wrap(song_wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) note_in <= rom[rom_addr];

   task automatic tick1();
      @(posedge clk);
      nclk++;
      #1;
   endtask

   // advance to beat b of the current slot (slot beat 0 follows edge base)
   task automatic at(input int b);
      while (nclk < base + b) tick1();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      restart = 1'b0;
      repeat (3) tick1();
      compared++;
      if (rom_addr !== 8'd0) begin
         mismatched++;
         $display("FAIL reset_rom_addr got %0d want 0", rom_addr);
      end
      compared++;
      if (audio_out !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_audio_out got %b want 0", audio_out);
      end
      compared++;
      if (audio_en !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_audio_en got %b want 0", audio_en);
      end
      compared++;
      if (cur_note !== 8'd0) begin
         mismatched++;
         $display("FAIL reset_cur_note got %0d want 0", cur_note);
      end
      compared++;
      if (song_wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_song_wrap got %b want 0", song_wrap);
      end
   endtask

   task automatic test_start();
      int cnt;
      rst_n = 1'b1;
      enable = 1'b1;
      base = nclk + 1;
      at(0);
      compared++;
      if (rom_addr !== 8'd0 || audio_en !== 1'b0) begin
         mismatched++;
         $display("FAIL start_fetch got addr=%0d en=%b want 0/0", rom_addr, audio_en);
      end
      at(2);
      compared++;
      if (cur_note !== 8'd27 || audio_en !== 1'b0) begin
         mismatched++;
         $display("FAIL start_cur_note got %0d en=%b want 27/0", cur_note, audio_en);
      end
      at(3);
      compared++;
      if (audio_en !== 1'b1 || audio_out !== 1'b0) begin
         mismatched++;
         $display("FAIL start_play_entry got en=%b out=%b want 1/0", audio_en, audio_out);
      end
      cnt = 0;
      while (audio_out === 1'b0 && cnt < 400) begin
         tick1();
         cnt++;
      end
      compared++;
      if (cnt !== 156) begin
         mismatched++;
         $display("FAIL start_first_toggle got %0d want 156", cnt);
      end
      at(1799);
      compared++;
      if (audio_en !== 1'b1) begin
         mismatched++;
         $display("FAIL start_last_play got en=%b want 1", audio_en);
      end
      at(1800);
      compared++;
      if (audio_en !== 1'b0 || audio_out !== 1'b0) begin
         mismatched++;
         $display("FAIL start_gap got en=%b out=%b want 0/0", audio_en, audio_out);
      end
      at(1999);
      compared++;
      if (rom_addr !== 8'd0) begin
         mismatched++;
         $display("FAIL start_slot_end got %0d want 0", rom_addr);
      end
      base += BEAT;
      at(0);
      compared++;
      if (rom_addr !== 8'd1) begin
         mismatched++;
         $display("FAIL start_advance got %0d want 1", rom_addr);
      end
   endtask

   task automatic test_pitch();
      int note_e[3] = '{26, 22, 24};
      int half_e[3] = '{166, 209, 186};
      int lo;
      int hi;
      for (int i = 0; i < 3; i++) begin
         at(2);
         compared++;
         if (cur_note !== 8'(note_e[i])) begin
            mismatched++;
            $display("FAIL pitch_note%0d got %0d want %0d", i, cur_note, note_e[i]);
         end
         at(3);
         lo = 0;
         while (audio_out === 1'b0 && lo < 400) begin
            tick1();
            lo++;
         end
         hi = 0;
         while (audio_out === 1'b1 && hi < 400) begin
            tick1();
            hi++;
         end
         compared++;
         if (lo !== half_e[i] || hi !== half_e[i]) begin
            mismatched++;
            $display("FAIL pitch_half%0d got lo=%0d hi=%0d want %0d", i, lo, hi, half_e[i]);
         end
         at(1999);
         compared++;
         if (rom_addr !== 8'(i + 1)) begin
            mismatched++;
            $display("FAIL pitch_slot_end%0d got %0d want %0d", i, rom_addr, i + 1);
         end
         base += BEAT;
         at(0);
         compared++;
         if (rom_addr !== 8'(i + 2)) begin
            mismatched++;
            $display("FAIL pitch_slot_len%0d got %0d want %0d", i, rom_addr, i + 2);
         end
      end
   endtask

   // silent slot check shared shape for rest (addr 4) and out-of-range (addr 6)
   task automatic test_silent(input int addr, input int note);
      int bad;
      at(2);
      compared++;
      if (cur_note !== 8'(note)) begin
         mismatched++;
         $display("FAIL silent_note%0d got %0d want %0d", addr, cur_note, note);
      end
      bad = 0;
      for (int b = 2; b < BEAT; b++) begin
         at(b);
         if (audio_out !== 1'b0 || audio_en !== 1'b0) bad++;
      end
      compared++;
      if (bad !== 0) begin
         mismatched++;
         $display("FAIL silent_slot%0d got %0d noisy cycles want 0", addr, bad);
      end
      base += BEAT;
      at(0);
      compared++;
      if (rom_addr !== 8'(addr + 1)) begin
         mismatched++;
         $display("FAIL silent_advance%0d got %0d want %0d", addr, rom_addr, addr + 1);
      end
   endtask

   task automatic test_pause();
      int cnt;
      at(500);
      compared++;
      if (audio_en !== 1'b1 || rom_addr !== 8'd5) begin
         mismatched++;
         $display("FAIL pause_pre got en=%b addr=%0d want 1/5", audio_en, rom_addr);
      end
      enable = 1'b0;
      tick1();
      compared++;
      if (audio_out !== 1'b0 || audio_en !== 1'b0 || rom_addr !== 8'd5) begin
         mismatched++;
         $display("FAIL pause_stop got out=%b en=%b addr=%0d want 0/0/5", audio_out, audio_en, rom_addr);
      end
      repeat (20) tick1();
      compared++;
      if (audio_en !== 1'b0 || rom_addr !== 8'd5) begin
         mismatched++;
         $display("FAIL pause_hold got en=%b addr=%0d want 0/5", audio_en, rom_addr);
      end
      enable = 1'b1;
      base = nclk + 1;
      at(3);
      compared++;
      if (audio_en !== 1'b1 || cur_note !== 8'd27) begin
         mismatched++;
         $display("FAIL resume_play got en=%b note=%0d want 1/27", audio_en, cur_note);
      end
      cnt = 0;
      while (audio_out === 1'b0 && cnt < 400) begin
         tick1();
         cnt++;
      end
      compared++;
      if (cnt !== 156) begin
         mismatched++;
         $display("FAIL resume_toggle got %0d want 156", cnt);
      end
      at(1999);
      compared++;
      if (rom_addr !== 8'd5) begin
         mismatched++;
         $display("FAIL resume_slot_end got %0d want 5", rom_addr);
      end
      base += BEAT;
      at(0);
      compared++;
      if (rom_addr !== 8'd6) begin
         mismatched++;
         $display("FAIL resume_advance got %0d want 6", rom_addr);
      end
   endtask

   task automatic test_wrap();
      int target;
      int range_bad;
      int pulses;
      logic [7:0] prev;
      logic [7:0] w_prev;
      logic [7:0] w_cur;
      target = base + (SL - 7) * BEAT + 2;
      range_bad = 0;
      pulses = 0;
      prev = rom_addr;
      w_prev = 8'hff;
      w_cur = 8'hff;
      while (nclk < target) begin
         tick1();
         if (rom_addr > 8'd31) range_bad++;
         if (song_wrap === 1'b1) begin
            pulses++;
            w_prev = prev;
            w_cur = rom_addr;
         end
         prev = rom_addr;
      end
      base += (SL - 7) * BEAT;
      compared++;
      if (range_bad !== 0) begin
         mismatched++;
         $display("FAIL wrap_range got %0d bad cycles want 0", range_bad);
      end
      compared++;
      if (pulses !== 1) begin
         mismatched++;
         $display("FAIL wrap_pulses got %0d want 1", pulses);
      end
      compared++;
      if (w_prev !== 8'd31 || w_cur !== 8'd0) begin
         mismatched++;
         $display("FAIL wrap_edge got %0d->%0d want 31->0", w_prev, w_cur);
      end
   endtask

   task automatic test_restart();
      int cnt;
      int wraps;
      base += 2 * BEAT;
      at(700);
      compared++;
      if (rom_addr !== 8'd2) begin
         mismatched++;
         $display("FAIL restart_pre got %0d want 2", rom_addr);
      end
      restart = 1'b1;
      tick1();
      restart = 1'b0;
      base = nclk;
      compared++;
      if (rom_addr !== 8'd0 || song_wrap !== 1'b0 || audio_en !== 1'b0) begin
         mismatched++;
         $display("FAIL restart_jump got addr=%0d wrap=%b en=%b want 0/0/0", rom_addr, song_wrap, audio_en);
      end
      wraps = 0;
      for (int b = 1; b <= 3; b++) begin
         at(b);
         if (song_wrap !== 1'b0) wraps++;
      end
      compared++;
      if (cur_note !== 8'd27 || audio_en !== 1'b1 || wraps !== 0) begin
         mismatched++;
         $display("FAIL restart_note got note=%0d en=%b wraps=%0d want 27/1/0", cur_note, audio_en, wraps);
      end
      cnt = 0;
      while (audio_out === 1'b0 && cnt < 400) begin
         tick1();
         cnt++;
      end
      compared++;
      if (cnt !== 156) begin
         mismatched++;
         $display("FAIL restart_toggle got %0d want 156", cnt);
      end
      base += BEAT;
      at(300);
      compared++;
      if (rom_addr !== 8'd1) begin
         mismatched++;
         $display("FAIL restart_off_pre got %0d want 1", rom_addr);
      end
      enable = 1'b0;
      restart = 1'b1;
      tick1();
      restart = 1'b0;
      compared++;
      if (rom_addr !== 8'd0 || audio_en !== 1'b0 || song_wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL restart_off got addr=%0d en=%b wrap=%b want 0/0/0", rom_addr, audio_en, song_wrap);
      end
      repeat (30) tick1();
      compared++;
      if (rom_addr !== 8'd0 || audio_en !== 1'b0 || audio_out !== 1'b0) begin
         mismatched++;
         $display("FAIL restart_idle got addr=%0d en=%b out=%b want 0/0/0", rom_addr, audio_en, audio_out);
      end
      enable = 1'b1;
      base = nclk + 1;
      at(3);
      compared++;
      if (rom_addr !== 8'd0 || cur_note !== 8'd27 || audio_en !== 1'b1) begin
         mismatched++;
         $display("FAIL restart_resume got addr=%0d note=%0d en=%b want 0/27/1", rom_addr, cur_note, audio_en);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[i] = (i < SL) ? 8'd27 : 8'd0;
      end
      rom[1] = 8'd26;
      rom[2] = 8'd22;
      rom[3] = 8'd24;
      rom[4] = 8'd0;
      rom[5] = 8'd27;
      rom[6] = 8'd250;
      test_reset();
      test_start();
      test_pitch();
      test_silent(4, 0);
      test_pause();
      test_silent(6, 250);
      test_wrap();
      test_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
